// File: rtl/game_over_ctrl_pkg.sv
// Shared game-over types and screen constants.
// Also used by the draw modules for the active-area limits.
package game_over_ctrl_pkg;

   localparam int XW = 10;
   localparam int SCREEN_H_LAST = 639;
   localparam int SCREEN_V_LAST = 479;

   typedef enum logic [1:0] {
      RUN,
      OVER,
      ARMED,
      RESTART
   } goState_t;

   // Counter width for a modulo-n count, never narrower than 1 bit.
   function automatic int cntWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/game_over_ctrl_if.sv
// Pixel-side inputs and status outputs of the game-over block.
// master = pixel/button source, slave = game_over_ctrl.
interface game_over_ctrl_if;
   import game_over_ctrl_pkg::*;

   logic          pix_en;
   logic [XW-1:0] x;
   logic [XW-1:0] y;
   logic          video_on;
   logic          goose_px;
   logic          obstacle_px;
   logic          btn_restart;
   logic          hit;
   logic          blink;
   logic          run;
   logic          restart;

   modport master (
      output pix_en,
      output x,
      output y,
      output video_on,
      output goose_px,
      output obstacle_px,
      output btn_restart,
      input  hit,
      input  blink,
      input  run,
      input  restart
   );

   modport slave (
      input  pix_en,
      input  x,
      input  y,
      input  video_on,
      input  goose_px,
      input  obstacle_px,
      input  btn_restart,
      output hit,
      output blink,
      output run,
      output restart
   );

endinterface

// File: rtl/game_over_ctrl_btn_sync_edge.sv
// Two-flop synchroniser plus one-clock rising-edge pulse.
// Generic enough for any of the game buttons.
module btn_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic btnAsync,
   output logic rise
);

   logic meta;
   logic sync;
   logic syncQ;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta  <= 1'b0;
         sync  <= 1'b0;
         syncQ <= 1'b0;
      end else begin
         meta  <= btnAsync;
         sync  <= meta;
         syncQ <= sync;
      end
   end

   assign rise = sync & ~syncQ;

endmodule

// File: rtl/game_over_ctrl.sv
// Goose/obstacle collision detect and game-over sequencing.
// Commits game-over at frame end, holds, then waits for a restart press.
module game_over_ctrl
   import game_over_ctrl_pkg::*;
#(
   parameter int H_LAST       = SCREEN_H_LAST,
   parameter int V_LAST       = SCREEN_V_LAST,
   parameter int HOLD_FRAMES  = 60,
   parameter int BLINK_FRAMES = 30
) (
   input logic clk,
   input logic rst_n,
   game_over_ctrl_if.slave bus
);

   localparam int HW = cntWidth(HOLD_FRAMES);
   localparam int BW = cntWidth(BLINK_FRAMES);

   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_FRAMES - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
   localparam logic [XW-1:0] X_LAST     = XW'(H_LAST);
   localparam logic [XW-1:0] Y_LAST     = XW'(V_LAST);

   goState_t      state;
   goState_t      stateNext;
   logic [HW-1:0] holdCnt;
   logic [HW-1:0] holdNext;
   logic [BW-1:0] blinkCnt;
   logic [BW-1:0] blinkCntNext;
   logic          blinkQ;
   logic          blinkNext;
   logic          hitQ;
   logic          runQ;
   logic          restartQ;

   logic          frameTick;
   logic          collPx;
   logic          collFlag;
   logic          collSeen;
   logic          btnRise;

   logic          blinkWrap;
   logic [BW-1:0] stepCnt;
   logic          stepBlink;

   btn_sync_edge u_btn (
      .clk      (clk),
      .rst_n    (rst_n),
      .btnAsync (bus.btn_restart),
      .rise     (btnRise)
   );

   assign frameTick = bus.pix_en
                    & (bus.x == X_LAST)
                    & (bus.y == Y_LAST);

   assign collPx = bus.pix_en
                 & bus.video_on
                 & bus.goose_px
                 & bus.obstacle_px;

   // A hit on the very last pixel still counts for this frame.
   assign collSeen = collFlag | collPx;

   assign blinkWrap = (blinkCnt == BLINK_LAST);
   assign stepCnt   = blinkWrap ? '0 : blinkCnt + 1'b1;
   assign stepBlink = blinkWrap ? ~blinkQ : blinkQ;

   always_comb begin
      stateNext    = state;
      holdNext     = holdCnt;
      blinkCntNext = blinkCnt;
      blinkNext    = blinkQ;
      unique case (state)
         RUN: begin
            holdNext     = '0;
            blinkCntNext = '0;
            blinkNext    = 1'b1;
            if (frameTick && collSeen) begin
               stateNext = OVER;
            end
         end
         OVER: begin
            if (frameTick) begin
               blinkCntNext = stepCnt;
               blinkNext    = stepBlink;
               if (holdCnt == HOLD_LAST) begin
                  stateNext = ARMED;
               end else begin
                  holdNext = holdCnt + 1'b1;
               end
            end
         end
         ARMED: begin
            if (btnRise) begin
               stateNext    = RESTART;
               blinkCntNext = '0;
               blinkNext    = 1'b1;
            end else if (frameTick) begin
               blinkCntNext = stepCnt;
               blinkNext    = stepBlink;
            end
         end
         RESTART: begin
            stateNext    = RUN;
            holdNext     = '0;
            blinkCntNext = '0;
            blinkNext    = 1'b1;
         end
         default: begin
            stateNext = RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         holdCnt  <= '0;
         blinkCnt <= '0;
         blinkQ   <= 1'b1;
         hitQ     <= 1'b0;
         runQ     <= 1'b1;
         restartQ <= 1'b0;
      end else begin
         state    <= stateNext;
         holdCnt  <= holdNext;
         blinkCnt <= blinkCntNext;
         blinkQ   <= blinkNext;
         hitQ     <= (stateNext == OVER)
                  || (stateNext == ARMED);
         runQ     <= (stateNext == RUN);
         restartQ <= (stateNext == RESTART);
      end
   end

   // Only armed while running; any other state drops it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         collFlag <= 1'b0;
      end else begin
         collFlag <= (state == RUN)
                  && !frameTick
                  && collSeen;
      end
   end

   assign bus.hit     = hitQ;
   assign bus.blink   = blinkQ;
   assign bus.run     = runQ;
   assign bus.restart = restartQ;

endmodule

// File: tb/tb_game_over_ctrl.sv
// Scoreboard bench for game_over_ctrl on a shrunken 8x4 screen.
// Expected output changes are queued with their cycle number.
module tb_game_over_ctrl;
   import game_over_ctrl_pkg::*;

   localparam int HL    = 7;
   localparam int VL    = 3;
   localparam int HOLD  = 4;
   localparam int BLINK = 2;

   typedef struct {
      int         at;
      logic [3:0] v;
   } expT;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;

   expT        expQ[$];
   expT        mExp;
   int         nVec = 0;
   int         nBad = 0;
   bit         monOn = 1'b0;
   logic [3:0] prev = 4'b0110;
   logic [3:0] outV;
   int         t;
   int         c;

   game_over_ctrl_if bus ();

   game_over_ctrl #(
      .H_LAST       (HL),
      .V_LAST       (VL),
      .HOLD_FRAMES  (HOLD),
      .BLINK_FRAMES (BLINK)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // {hit, blink, run, restart}
   assign outV = {bus.hit, bus.blink, bus.run, bus.restart};

   always @(negedge clk) begin
      if (monOn && outV !== prev) begin
         nVec++;
         if (expQ.size() == 0) begin
            nBad++;
            $display("FAIL unexpected_change cyc=%0d got=%b want=%b",
                     cyc, outV, prev);
         end else begin
            mExp = expQ.pop_front();
            if (mExp.at != cyc || mExp.v !== outV) begin
               nBad++;
               $display("FAIL out_change cyc=%0d got=%b want=%b at cyc %0d",
                        cyc, outV, mExp.v, mExp.at);
            end
         end
         prev = outV;
      end
   end

   task automatic pushExp(input int at, input logic [3:0] v);
      expT e;
      e.at = at;
      e.v  = v;
      expQ.push_back(e);
   endtask

   task automatic idle(input int n);
      bus.pix_en      = 1'b0;
      bus.goose_px    = 1'b0;
      bus.obstacle_px = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One frame; overlap only at (cx,cy), with video_on=vOn there.
   task automatic frame(input int cx, input int cy,
                        input bit vOn, output int tick);
      bit hp;
      for (int yy = 0; yy <= VL; yy++) begin
         for (int xx = 0; xx <= HL; xx++) begin
            hp = (xx == cx) && (yy == cy);
            bus.pix_en      = 1'b1;
            bus.x           = XW'(xx);
            bus.y           = XW'(yy);
            bus.video_on    = hp ? vOn : 1'b1;
            bus.goose_px    = hp || (xx == 1 && yy == 1);
            bus.obstacle_px = hp || (xx == 5 && yy == 0);
            @(posedge clk);
            #1;
         end
      end
      tick = cyc;
      bus.pix_en      = 1'b0;
      bus.goose_px    = 1'b0;
      bus.obstacle_px = 1'b0;
   endtask

   // Commit at tick 0, blink toggles on ticks 2 and 4, ARMED after tick 4.
   task automatic overToArmed(input int cx, input int cy);
      int tk;
      frame(cx, cy, 1'b1, tk);
      pushExp(tk, 4'b1100);
      frame(-1, -1, 1'b1, tk);
      frame(-1, -1, 1'b1, tk);
      pushExp(tk, 4'b1000);
      frame(-1, -1, 1'b1, tk);
      frame(-1, -1, 1'b1, tk);
      pushExp(tk, 4'b1100);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
      $fatal(1);
   end

   initial begin
      bus.pix_en      = 1'b0;
      bus.x           = '0;
      bus.y           = '0;
      bus.video_on    = 1'b0;
      bus.goose_px    = 1'b0;
      bus.obstacle_px = 1'b0;
      bus.btn_restart = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      nVec++;
      if (outV !== 4'b0110) begin
         nBad++;
         $display("FAIL reset_state got=%b want=0110", outV);
      end
      rst_n = 1'b1;
      monOn = 1'b1;
      idle(2);

      // Clean frames: no transitions at all.
      repeat (3) frame(-1, -1, 1'b1, t);

      // Mid-frame overlap; button held across OVER into ARMED.
      frame(3, 2, 1'b1, t);
      pushExp(t, 4'b1100);
      idle(3);
      frame(-1, -1, 1'b1, t);
      bus.btn_restart = 1'b1;
      idle(4);
      frame(-1, -1, 1'b1, t);
      pushExp(t, 4'b1000);
      frame(-1, -1, 1'b1, t);
      frame(-1, -1, 1'b1, t);
      pushExp(t, 4'b1100);
      frame(-1, -1, 1'b1, t);
      frame(-1, -1, 1'b1, t);
      pushExp(t, 4'b1000);
      idle(3);
      bus.btn_restart = 1'b0;
      idle(5);
      bus.btn_restart = 1'b1;
      c = cyc;
      pushExp(c + 3, 4'b0101);
      pushExp(c + 4, 4'b0110);
      idle(6);
      bus.btn_restart = 1'b0;
      idle(4);

      // Overlap only on the frame_tick pixel.
      frame(-1, -1, 1'b1, t);
      overToArmed(HL, VL);
      idle(2);
      bus.btn_restart = 1'b1;
      c = cyc;
      pushExp(c + 3, 4'b0101);
      pushExp(c + 4, 4'b0110);
      idle(6);
      bus.btn_restart = 1'b0;
      idle(4);

      // Overlap outside active video is ignored.
      frame(3, 2, 1'b0, t);
      frame(-1, -1, 1'b1, t);

      // Async reset mid-ARMED, then a press that must do nothing.
      overToArmed(2, 1);
      idle(2);
      #2;
      rst_n = 1'b0;
      pushExp(cyc, 4'b0110);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(3);
      bus.btn_restart = 1'b1;
      idle(8);
      bus.btn_restart = 1'b0;
      idle(3);
      frame(-1, -1, 1'b1, t);
      idle(4);

      monOn = 1'b0;
      while (expQ.size() != 0) begin
         mExp = expQ.pop_front();
         nVec++;
         nBad++;
         $display("FAIL missing_change got=none want=%b at cyc %0d",
                  mExp.v, mExp.at);
      end
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
      $finish;
   end

endmodule
